bist_result_checker: RTL and testbench

Downstream consumer of the BIST signature analyzer. It counts DUT output beats, drives the analyzer's stop request once the programmed pattern count is reached, and captures the final MISR signature. It then compares the signature against a golden value and presents a sticky pass/fail result to the test controller or status registers.

---
 rtl/bist_pkg.sv | 16 +
 rtl/bist_watchdog.sv | 37 +++
 rtl/bist_result_checker.sv | 166 ++++++++++++++++
 tb/tb_bist_result_checker.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared types and defaults for the BIST result checker
// Watchdog defaults apply only when BIST_TIMEOUT_EN is defined.
package bist_pkg;

  localparam int unsigned DATA_WIDTH_DEF     = 64;
  localparam int unsigned CNT_WIDTH_DEF      = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_SIG,
    DONE
  } st_bist_chk_state;

endpackage

// File: rtl/bist_watchdog.sv
// rtl/bist_watchdog.sv - cycle watchdog, expires after TIMEOUT_CYCLES enabled cycles
// Instantiated by bist_result_checker only when BIST_TIMEOUT_EN is defined.
module bist_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry is flagged on the edge that would complete the last enabled cycle.
  assign expire_o = enable_i && !clear_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bist_result_checker.sv
// rtl/bist_result_checker.sv - counts DUT beats, stops the MISR, compares signature to golden
// Optional watchdog enabled with `define BIST_TIMEOUT_EN.
module bist_result_checker
  import bist_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
`ifdef BIST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  num_patterns_i,
  input  logic [DATA_WIDTH-1:0] golden_i,
  input  logic                  dut_valid_i,
  output logic                  stop_o,
  input  logic                  sig_valid_i,
  input  logic [DATA_WIDTH-1:0] sig_data_i,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic [DATA_WIDTH-1:0] signature_o,
  output logic [CNT_WIDTH-1:0]  beat_count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  st_bist_chk_state      state_q, state_d;
  logic [CNT_WIDTH-1:0]  n_q, n_d;
  logic [DATA_WIDTH-1:0] golden_q, golden_d;
  logic [CNT_WIDTH-1:0]  beat_q, beat_d;
  logic [DATA_WIDTH-1:0] sig_q, sig_d;
  logic                  pass_q, pass_d;
  logic                  fail_q, fail_d;
  logic                  timeout_q, timeout_d;
  logic                  stop_q, stop_d;
  logic                  done_q, done_d;

  logic                  beat_inc;
  logic [CNT_WIDTH-1:0]  beat_next;
  logic                  wd_expire;

`ifdef BIST_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (((state_q == IDLE) || (state_q == DONE)) && start_i) || beat_inc;
  assign wd_enable = (state_q == COUNT) || (state_q == WAIT_SIG);

  bist_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (wd_clear),
    .enable_i(wd_enable),
    .expire_o(wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    golden_d  = golden_q;
    beat_d    = beat_q;
    sig_d     = sig_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    stop_d    = stop_q;
    done_d    = done_q;
    beat_inc  = 1'b0;
    beat_next = beat_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = COUNT;
          n_d       = num_patterns_i;
          golden_d  = golden_i;
          beat_d    = '0;
          sig_d     = '0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          stop_d    = 1'b0;
          done_d    = 1'b0;
        end
      end
      COUNT: begin
        // Beats past N are dropped; the counter also never wraps past all-ones.
        beat_inc  = dut_valid_i && (beat_q != n_q) && (beat_q != CNT_MAX);
        beat_next = beat_q + CNT_WIDTH'(beat_inc);
        beat_d    = beat_next;
        if (beat_next == n_q) begin
          stop_d  = 1'b1;
          state_d = WAIT_SIG;
        end else if (wd_expire) begin
          state_d   = DONE;
          stop_d    = 1'b1;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          pass_d    = 1'b0;
        end
      end
      WAIT_SIG: begin
        if (sig_valid_i) begin
          state_d = DONE;
          done_d  = 1'b1;
          sig_d   = sig_data_i;
          pass_d  = (sig_data_i == golden_q);
          fail_d  = (sig_data_i != golden_q);
        end else if (wd_expire) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          fail_d    = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      n_q       <= '0;
      golden_q  <= '0;
      beat_q    <= '0;
      sig_q     <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      stop_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      golden_q  <= golden_d;
      beat_q    <= beat_d;
      sig_q     <= sig_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
    end
  end

  assign stop_o       = stop_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign fail_o       = fail_q;
  assign timeout_o    = timeout_q;
  assign signature_o  = sig_q;
  assign beat_count_o = beat_q;

endmodule

// File: tb/tb_bist_result_checker.sv
// tb/tb_bist_result_checker.sv - directed table-driven bench for bist_result_checker
// Covers the watchdog scenario when compiled with BIST_TIMEOUT_EN.
module tb_bist_result_checker;

  logic        clk_i          = 1'b0;
  logic        rstn_i         = 1'b0;
  logic        start_i        = 1'b0;
  logic [15:0] num_patterns_i = '0;
  logic [63:0] golden_i       = '0;
  logic        dut_valid_i    = 1'b0;
  logic        sig_valid_i    = 1'b0;
  logic [63:0] sig_data_i     = '0;
  logic        stop_o;
  logic        done_o;
  logic        pass_o;
  logic        fail_o;
  logic        timeout_o;
  logic [63:0] signature_o;
  logic [15:0] beat_count_o;

  int n_pass  = 0;
  int n_total = 0;

  bist_result_checker #(
    .DATA_WIDTH(64),
    .CNT_WIDTH (16)
`ifdef BIST_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .start_i       (start_i),
    .num_patterns_i(num_patterns_i),
    .golden_i      (golden_i),
    .dut_valid_i   (dut_valid_i),
    .stop_o        (stop_o),
    .sig_valid_i   (sig_valid_i),
    .sig_data_i    (sig_data_i),
    .done_o        (done_o),
    .pass_o        (pass_o),
    .fail_o        (fail_o),
    .timeout_o     (timeout_o),
    .signature_o   (signature_o),
    .beat_count_o  (beat_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [15:0] n;
    logic [63:0] golden;
    int          beats;
    logic [63:0] sig;
    logic        exp_pass;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stop"}, 64'(stop_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_pass"}, 64'(pass_o), 64'd0);
    chk({tag, "_fail"}, 64'(fail_o), 64'd0);
    chk({tag, "_tmo"},  64'(timeout_o), 64'd0);
    chk({tag, "_sig"},  signature_o, 64'd0);
    chk({tag, "_cnt"},  64'(beat_count_o), 64'd0);
  endtask

  task automatic do_start(input logic [15:0] n, input logic [63:0] g);
    num_patterns_i = n;
    golden_i       = g;
    start_i        = 1'b1;
    tick();
    start_i        = 1'b0;
    num_patterns_i = 16'h5555;
    golden_i       = 64'hFFFF_0000_FFFF_0000;
  endtask

  task automatic beat();
    dut_valid_i = 1'b1;
    tick();
    dut_valid_i = 1'b0;
  endtask

  task automatic send_sig(input logic [63:0] s);
    sig_data_i  = s;
    sig_valid_i = 1'b1;
    tick();
    sig_valid_i = 1'b0;
    sig_data_i  = 64'h0BAD_0BAD_0BAD_0BAD;
  endtask

  initial begin
    vecs[0] = '{16'd4, 64'hDEAD_BEEF_0000_0001, 4, 64'hDEAD_BEEF_0000_0001, 1'b1, 16'd4};
    vecs[1] = '{16'd4, 64'h2, 4, 64'h1, 1'b0, 16'd4};
    vecs[2] = '{16'd0, 64'h5, 5, 64'h5, 1'b1, 16'd0};
    vecs[3] = '{16'd1, 64'hAAAA_AAAA_AAAA_AAAA, 3, 64'hAAAA_AAAA_AAAA_AAAB, 1'b0, 16'd1};
    vecs[4] = '{16'd7, 64'h0, 7, 64'h0, 1'b1, 16'd7};

    tick();
    tick();
    chk_all_zero("reset");
    rstn_i = 1'b1;
    tick();
    chk_all_zero("idle");

    for (int v = 0; v < 5; v++) begin
      do_start(vecs[v].n, vecs[v].golden);
      chk_all_zero($sformatf("v%0d_start", v));
      for (int b = 0; b < vecs[v].beats; b++) begin
        beat();
        chk($sformatf("v%0d_b%0d_stop", v, b), 64'(stop_o),
            64'((b + 1) >= int'(vecs[v].n)));
        chk($sformatf("v%0d_b%0d_cnt", v, b), 64'(beat_count_o),
            64'(((b + 1) < int'(vecs[v].n)) ? (b + 1) : int'(vecs[v].n)));
        tick();
      end
      chk($sformatf("v%0d_pre_done", v), 64'(done_o), 64'd0);
      send_sig(vecs[v].sig);
      chk($sformatf("v%0d_done", v), 64'(done_o), 64'd1);
      chk($sformatf("v%0d_pass", v), 64'(pass_o), 64'(vecs[v].exp_pass));
      chk($sformatf("v%0d_fail", v), 64'(fail_o), 64'(!vecs[v].exp_pass));
      chk($sformatf("v%0d_sig", v), signature_o, vecs[v].sig);
      chk($sformatf("v%0d_cnt", v), 64'(beat_count_o), 64'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_stop", v), 64'(stop_o), 64'd1);
      chk($sformatf("v%0d_tmo", v), 64'(timeout_o), 64'd0);
    end

    // DONE holds results against stray sig_valid_i and dut_valid_i.
    send_sig(64'h1234);
    beat();
    chk("done_hold_sig", signature_o, 64'h0);
    chk("done_hold_cnt", 64'(beat_count_o), 64'd7);
    chk("done_hold_pass", 64'(pass_o), 64'd1);

    // N=0: COUNT after start, WAIT_SIG with stop one cycle later.
    do_start(16'd0, 64'h77);
    chk("n0_stop_after_start", 64'(stop_o), 64'd0);
    tick();
    chk("n0_stop_next", 64'(stop_o), 64'd1);
    chk("n0_done_next", 64'(done_o), 64'd0);
    send_sig(64'h77);
    chk("n0_pass", 64'(pass_o), 64'd1);

    // start_i and sig_valid_i during COUNT are ignored.
    do_start(16'd3, 64'hCAFE);
    beat();
    num_patterns_i = 16'd1;
    golden_i       = 64'hBEEF;
    start_i        = 1'b1;
    tick();
    start_i        = 1'b0;
    chk("ign_start_cnt", 64'(beat_count_o), 64'd1);
    chk("ign_start_stop", 64'(stop_o), 64'd0);
    send_sig(64'hBEEF);
    chk("ign_sig_done", 64'(done_o), 64'd0);
    chk("ign_sig_sig", signature_o, 64'd0);
    beat();
    chk("ign_b2_stop", 64'(stop_o), 64'd0);
    beat();
    chk("ign_b3_stop", 64'(stop_o), 64'd1);
    chk("ign_b3_cnt", 64'(beat_count_o), 64'd3);
    send_sig(64'hCAFE);
    chk("ign_pass", 64'(pass_o), 64'd1);
    chk("ign_sig", signature_o, 64'hCAFE);

    // Async reset while waiting for the signature.
    do_start(16'd2, 64'h42);
    beat();
    beat();
    chk("rst_pre_stop", 64'(stop_o), 64'd1);
    rstn_i = 1'b0;
    #2;
    chk_all_zero("rst_async");
    tick();
    rstn_i = 1'b1;
    tick();
    chk_all_zero("rst_after");
    do_start(16'd2, 64'h42);
    beat();
    beat();
    send_sig(64'h42);
    chk("rst_rerun_pass", 64'(pass_o), 64'd1);
    chk("rst_rerun_cnt", 64'(beat_count_o), 64'd2);

`ifdef BIST_TIMEOUT_EN
    // Watchdog: 16 cycles after the last counted beat.
    do_start(16'd8, 64'h99);
    beat();
    beat();
    for (int i = 0; i < 15; i++) tick();
    chk("wd_pre_tmo", 64'(timeout_o), 64'd0);
    chk("wd_pre_done", 64'(done_o), 64'd0);
    tick();
    chk("wd_tmo", 64'(timeout_o), 64'd1);
    chk("wd_fail", 64'(fail_o), 64'd1);
    chk("wd_pass", 64'(pass_o), 64'd0);
    chk("wd_done", 64'(done_o), 64'd1);
    chk("wd_stop", 64'(stop_o), 64'd1);
    chk("wd_sig", signature_o, 64'd0);
    chk("wd_cnt", 64'(beat_count_o), 64'd2);
`else
    // Without the watchdog a stalled run waits indefinitely.
    do_start(16'd8, 64'h99);
    beat();
    beat();
    for (int i = 0; i < 40; i++) tick();
    chk("nowd_tmo", 64'(timeout_o), 64'd0);
    chk("nowd_done", 64'(done_o), 64'd0);
    for (int i = 0; i < 6; i++) beat();
    chk("nowd_stop", 64'(stop_o), 64'd1);
    send_sig(64'h99);
    chk("nowd_pass", 64'(pass_o), 64'd1);
`endif

    // All-ones pattern count with continuous beats; extra beats are dropped.
    do_start(16'hFFFF, 64'h5A5A);
    dut_valid_i = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    chk("sat_cnt", 64'(beat_count_o), 64'hFFFF);
    chk("sat_stop", 64'(stop_o), 64'd1);
    tick();
    tick();
    dut_valid_i = 1'b0;
    chk("sat_cnt_hold", 64'(beat_count_o), 64'hFFFF);
    send_sig(64'h5A5A);
    chk("sat_pass", 64'(pass_o), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
